// File: rtl/hex_display_scheduler.sv
// Binary-to-BCD display scheduler: serial double-dabble conversion feeding six
// seven-segment digit decoders, with leading-zero blanking and flicker-free hold.
module hex_display_scheduler #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_value,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_blank,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD_OUT} state_t;

  state_t                   state, state_nxt;
  logic [WIDTH-1:0]         bin_sr;
  logic [BCD_W-1:0]         bcd;
  logic [CNT_W-1:0]         cnt;
  logic                     blank_en;
  logic [BCD_W+WIDTH-1:0]   shifted;

  // Add 3 to every nibble >= 5 so the following left shift carries decimally.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] >= 4'd5)
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit k blanks when it and every digit above it are zero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v,
                                                   input logic en);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above & (v[4*k +: 4] == 4'd0);
      m[k]       = en & zero_above;
    end
    return m;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign shifted  = {add3(bcd), bin_sr} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_valid) state_nxt = SHIFT;
      SHIFT:    if (cnt == CNT_W'(1)) state_nxt = LOAD_OUT;
      LOAD_OUT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Conversion engine and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sr      <= '0;
      bcd         <= '0;
      cnt         <= '0;
      blank_en    <= 1'b0;
      digits      <= '0;
      digit_blank <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == LOAD_OUT);
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin_sr   <= in_value;
            blank_en <= blank_lz;
            bcd      <= '0;
            cnt      <= CNT_W'(WIDTH);
          end
        end
        SHIFT: begin
          bcd    <= shifted[BCD_W+WIDTH-1:WIDTH];
          bin_sr <= shifted[WIDTH-1:0];
          cnt    <= cnt - CNT_W'(1);
        end
        LOAD_OUT: begin
          digits      <= bcd;
          digit_blank <= blank_mask(bcd, blank_en);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler: driver pushes decimal-model expectations,
// a negedge monitor pops and compares on every done pulse and checks output hold.
module tb_hex_display_scheduler;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_value;
  logic                blank_lz;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   digit_blank;
  logic                busy;
  logic                done;

  typedef struct {
    logic [4*DIGITS-1:0] d;
    logic [DIGITS-1:0]   m;
    int                  acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  hex_display_scheduler #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .blank_lz(blank_lz), .digits(digits),
    .digit_blank(digit_blank), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] model_digits(input int v);
    logic [4*DIGITS-1:0] d;
    int x;
    x = v;
    d = '0;
    for (int k = 0; k < DIGITS; k++) begin
      d[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return d;
  endfunction

  function automatic logic [DIGITS-1:0] model_mask(input int v, input bit en);
    logic [DIGITS-1:0] m;
    int p;
    m = '0;
    p = 1;
    for (int k = 1; k < DIGITS; k++) begin
      p = p * 10;
      m[k] = en && (v < p);
    end
    return m;
  endfunction

  // Monitor: compare on done, otherwise the display must hold its last result
  logic [4*DIGITS-1:0] held_d = '0;
  logic [DIGITS-1:0]   held_m = '0;
  logic                prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_d    = '0;
      held_m    = '0;
      prev_done = 1'b0;
      check("done_in_reset", 32'(done), 32'd0);
    end else begin
      check("busy_vs_ready", 32'(busy), 32'(!in_ready));
      if (done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending result (cycle %0d)", cycle);
        end else begin
          e = q.pop_front();
          check("digits", 32'(digits), 32'(e.d));
          check("digit_blank", 32'(digit_blank), 32'(e.m));
          check("latency", 32'(cycle), 32'(e.acc + WIDTH + 1));
          held_d = e.d;
          held_m = e.m;
        end
      end else begin
        check("hold_digits", 32'(digits), 32'(held_d));
        check("hold_blank", 32'(digit_blank), 32'(held_m));
      end
      prev_done = done;
    end
  end

  task automatic send(input int v, input bit blz, input bit keep, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v[WIDTH-1:0];
    blank_lz = blz;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 required 1 within 100 cycles");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cycle + 1;
    q.push_back('{model_digits(v), model_mask(v, blz), acc});
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q.size() != 0 || !in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || !in_ready) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got %0d pending results required 0", q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int a, a2, n, gap;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    blank_lz = 1'b0;
    #1;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_blank", 32'(digit_blank), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1234 with blanking; measure the not-ready window
    send(1234, 1'b1, 1'b0, a);
    n = 0;
    do begin
      @(negedge clk);
      if (!in_ready) n++;
    end while (!in_ready && n < 100);
    check("ready_low_cycles", 32'(n), 32'(WIDTH + 1));
    wait_idle();

    send(0, 1'b1, 1'b0, a);      wait_idle();
    send(0, 1'b0, 1'b0, a);      wait_idle();
    send(65535, 1'b0, 1'b0, a);  wait_idle();

    // in_valid held through busy: second value waits for idle
    send(42, 1'b1, 1'b1, a);
    in_value = 16'd999;
    send(999, 1'b1, 1'b0, a2);
    check("held_valid_accept_gap", 32'(a2 - a), 32'(WIDTH + 2));
    wait_idle();

    // Reset in the middle of a conversion
    send(9999, 1'b0, 1'b0, a);
    n = 0;
    while (cycle < a + 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    check("midrst_digits", 32'(digits), 32'd0);
    check("midrst_blank", 32'(digit_blank), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_ready", 32'(in_ready), 32'd1);
    send(7, 1'b1, 1'b0, a);      wait_idle();

    // Inputs changing after accept must not disturb the conversion
    send(500, 1'b1, 1'b0, a);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_value = WIDTH'($urandom);
      blank_lz = 1'($urandom);
    end
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 65535)), 1'($urandom), 1'b0, a);
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Sequences a binary value onto the six decimal seven-segment digit decoders.
- Accepts a WIDTH-bit unsigned value over a valid/ready handshake and converts it to BCD with a serial shift-add-3 (double-dabble) engine, one bit per clock.
- Registers the per-digit 4-bit codes and a leading-zero blank mask. Downstream, each code feeds one digit decoder, and each blank bit forces its display to all-off (7'b1111111).
- Displayed outputs hold their last result during conversion, so there is no flicker.

Parameters:
- WIDTH, 16, binary input width; must satisfy 2^WIDTH-1 <= 10^DIGITS-1.
- DIGITS, 6, number of BCD digits / displays driven.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_value is presented.
- in_ready  output  1  block can accept; equals (state==IDLE).
- in_value  input  WIDTH  unsigned binary value to display.
- blank_lz  input  1  leading-zero blanking enable; sampled with in_value.
- digits  output  4*DIGITS  BCD codes; digit k at bits [4k+3:4k]; k=0 is the least significant digit.
- digit_blank  output  DIGITS  1 = display k is blanked.
- busy  output  1  conversion in progress; equals !in_ready.
- done  output  1  one-cycle pulse when digits/digit_blank update.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; digits=0, digit_blank=0, done=0; in_ready=1, busy=0.
  - Shift register, BCD accumulator and bit counter are cleared.
- States: IDLE, SHIFT, LOAD_OUT.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture in_value into the binary shift register, capture blank_lz, clear the BCD accumulator (4*DIGITS bits), set the counter to WIDTH, and go to SHIFT.
  - With in_valid=0, stay in IDLE.
- SHIFT:
  - Each edge, first add 3 to every BCD nibble that is >=5.
  - Then shift {BCD, binary} left by one, so the binary MSB enters BCD bit 0.
  - Decrement the counter; on the edge where the counter goes 1->0, go to LOAD_OUT.
  - This is exactly WIDTH shift edges. The counter width is clog2(WIDTH+1).
- LOAD_OUT:
  - On the next edge, register the BCD accumulator into digits, register the computed mask into digit_blank, set done=1, and go to IDLE.
  - done clears on the following edge unless another LOAD_OUT occurs (it cannot be back-to-back).
- Blank mask:
  - If the captured blank_lz=0, the mask is all 0.
  - Otherwise bit k=1 iff digits k..DIGITS-1 are all zero and k>0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Latency:
  - Accept edge = edge 0; outputs and done are visible after edge WIDTH+1 (17 with defaults).
  - in_ready is low for WIDTH+1 cycles; the next accept is possible at edge WIDTH+2 at the earliest.
- in_valid asserted while busy: ignored, with no capture and no queuing. The requester must hold in_valid until in_ready=1.
- Changes to in_value/blank_lz after the accept edge have no effect on the running conversion.
- Reset mid-conversion: aborts; outputs return to reset values at once; no done pulse; the partial result is discarded.
- Nibble add-3 results never exceed 4 bits (max input nibble 9 before add-3 check, 7 -> 10 after shift is impossible by construction). Overflow beyond DIGITS is prevented by the parameter constraint.
- No combinational path from inputs to outputs except that in_ready and busy are decoded from state.

Test Plan:
- Reset, then in_value=16'd1234, blank_lz=1, in_valid pulse -> in_ready=0 for 17 cycles. After edge 17: digits = {0,0,1,2,3,4} (digit5..0), digit_blank=6'b110000, done high exactly one cycle.
- in_value=16'd0, blank_lz=1 -> digits all 0, digit_blank=6'b111110. Same value with blank_lz=0 -> digit_blank=6'b000000.
- in_value=16'd65535, blank_lz=0 -> digits={0,6,5,5,3,5}, digit_blank=0. In the 17 cycles before done, the prior digits remain unchanged.
- Accept 16'd42, then hold in_valid=1 with in_value=16'd999 throughout -> 999 ignored while busy, accepted at edge 18. Results after edge 17: {0,0,0,0,4,2}; after edge 35: {0,0,0,9,9,9}.
- Accept 16'd9999, assert reset at edge 8 for 2 cycles -> digits=0, digit_blank=0, done never pulses, in_ready=1. Then 16'd7 converts to {0,0,0,0,0,7}.
- Accept 16'd500 with blank_lz=1, toggle blank_lz and in_value during SHIFT -> result {0,0,0,5,0,0}, digit_blank=6'b111000.
